// File: rtl/mouse_bus_fifo.sv
// Memory-mapped mouse packet FIFO on the shared 8-bit processor bus.
// Optional saturating drop counter at offset +5 when MOUSE_FIFO_OVF_CNT_EN is defined.
module mouse_bus_fifo #(
    parameter logic [7:0]  BaseAddr  = 8'hA0,
    parameter int unsigned DepthLog2 = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    input  logic       MOUSE_PKT_VALID,
    input  logic [7:0] MOUSE_STATUS,
    input  logic [7:0] MOUSE_DX,
    input  logic [7:0] MOUSE_DY,
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK
);
    localparam int unsigned Depth = 2 ** DepthLog2;
    localparam int unsigned CntW  = DepthLog2 + 1;

    logic [DepthLog2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DepthLog2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 irq_q, irq_d;
    logic                 drive_q, drive_d;
    logic [7:0]           rdata_q, rdata_d;
    logic [23:0]          mem_q [Depth];

    logic       in_window;
    logic [2:0] offset;
    logic       not_empty;
    logic       full;
    logic       pop;
    logic       push;
    logic       drop;
    logic       ovf_clr;
    logic [23:0] head;
    logic [7:0]  stat;
    logic        unused_wdata;

    assign in_window = (BUS_ADDR[7:3] == BaseAddr[7:3]);
    assign offset    = BUS_ADDR[2:0];
    assign not_empty = (count_q != '0);
    assign full      = (count_q == CntW'(Depth));
    assign pop       = BUS_WE && in_window && (offset == 3'd4) && not_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push      = MOUSE_PKT_VALID && (!full || pop);
    assign drop      = MOUSE_PKT_VALID && full && !pop;
    assign ovf_clr   = BUS_WE && in_window && (offset == 3'd0) && BUS_DATA[2];
    assign head      = mem_q[rd_ptr_q];
    assign stat      = {4'(count_q), 1'b0, ovf_q, full, not_empty};
    assign unused_wdata = ^{BUS_DATA[7:3], BUS_DATA[1:0]};

    assign BUS_DATA            = drive_q ? rdata_q : 8'hZZ;
    assign BUS_INTERRUPT_RAISE = irq_q;

`ifdef MOUSE_FIFO_OVF_CNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_clr ? 8'h00 : ovf_cnt_q;
        if (drop && (ovf_cnt_d != 8'hFF))
            ovf_cnt_d = ovf_cnt_d + 8'h01;
    end

    always_ff @(posedge CLK) begin
        if (!RESET)
            ovf_cnt_q <= 8'h00;
        else
            ovf_cnt_q <= ovf_cnt_d;
    end
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push)
            wr_ptr_d = wr_ptr_q + DepthLog2'(1);
        if (pop)
            rd_ptr_d = rd_ptr_q + DepthLog2'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        // A drop in the same cycle as a clear leaves the flag set.
        ovf_d = (ovf_q && !ovf_clr) || drop;
        irq_d = irq_q;
        if (push)
            irq_d = 1'b1;
        else if (BUS_INTERRUPT_ACK)
            irq_d = 1'b0;
    end

    always_comb begin
        rdata_d = 8'h00;
        drive_d = 1'b0;
        if (in_window && !BUS_WE) begin
            drive_d = 1'b1;
            case (offset)
                3'd0:    rdata_d = stat;
                3'd1:    rdata_d = not_empty ? head[23:16] : 8'h00;
                3'd2:    rdata_d = not_empty ? head[15:8]  : 8'h00;
                3'd3:    rdata_d = not_empty ? head[7:0]   : 8'h00;
`ifdef MOUSE_FIFO_OVF_CNT_EN
                3'd5:    rdata_d = ovf_cnt_q;
`endif
                default: rdata_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
            drive_q  <= 1'b0;
            rdata_q  <= 8'h00;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_d;
            drive_q  <= drive_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage has no reset; entries are only observed through valid pointers.
    always_ff @(posedge CLK) begin
        if (RESET && push)
            mem_q[wr_ptr_q] <= {MOUSE_STATUS, MOUSE_DX, MOUSE_DY};
    end
endmodule

// File: tb/tb_mouse_bus_fifo.sv
// Bench for mouse_bus_fifo: directed vector table, drop-counter sequence,
// and random traffic against a queue-based reference model.
module tb_mouse_bus_fifo;
    localparam logic [7:0] Base  = 8'hA0;
    localparam int         Depth = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] bus_addr = 8'h00;
    logic       bus_we = 1'b0;
    logic       tb_oe = 1'b0;
    logic [7:0] tb_wd = 8'h00;
    logic       pkt_valid = 1'b0;
    logic [7:0] pkt_st = 8'h00, pkt_dx = 8'h00, pkt_dy = 8'h00;
    logic       ack = 1'b0;
    logic       irq;
    tri1  [7:0] bus_data;

    // Released bus floats high through the tri1 pull, so "released" reads as 8'hFF.
    assign bus_data = tb_oe ? tb_wd : 8'hzz;

    always #5 clk = ~clk;

    mouse_bus_fifo #(.BaseAddr(Base), .DepthLog2(2)) dut (
        .CLK(clk), .RESET(rst_n), .BUS_DATA(bus_data), .BUS_ADDR(bus_addr),
        .BUS_WE(bus_we), .MOUSE_PKT_VALID(pkt_valid), .MOUSE_STATUS(pkt_st),
        .MOUSE_DX(pkt_dx), .MOUSE_DY(pkt_dy), .BUS_INTERRUPT_RAISE(irq),
        .BUS_INTERRUPT_ACK(ack)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst_n;
        logic [7:0]  addr;
        logic        we;
        logic [7:0]  wd;
        logic        v;
        logic [23:0] pkt;
        logic        ack;
        logic [7:0]  exp_bus;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic r, logic [7:0] a, logic w, logic [7:0] d,
                                logic v, logic [23:0] p, logic k,
                                logic [7:0] eb, logic ei);
        vec_t t;
        t.rst_n = r; t.addr = a; t.we = w; t.wd = d; t.v = v; t.pkt = p;
        t.ack = k; t.exp_bus = eb; t.exp_irq = ei;
        vecs.push_back(t);
    endfunction

    // Each read is followed by an idle cycle so the bus is free before any write.
    function automatic void rd(logic [7:0] a, logic [7:0] eb, logic ei);
        add(1'b1, a, 1'b0, 8'h00, 1'b0, 24'h0, 1'b0, eb, ei);
        add(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 24'h0, 1'b0, 8'hFF, ei);
    endfunction

    function automatic void wr(logic [7:0] a, logic [7:0] d, logic ei);
        add(1'b1, a, 1'b1, d, 1'b0, 24'h0, 1'b0, 8'hFF, ei);
    endfunction

    function automatic void psh(logic [23:0] p);
        add(1'b1, 8'h00, 1'b0, 8'h00, 1'b1, p, 1'b0, 8'hFF, 1'b1);
    endfunction

    function automatic void ack_row();
        add(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 24'h0, 1'b1, 8'hFF, 1'b0);
    endfunction

    task automatic do_cycle(input logic r, input logic [7:0] a, input logic w,
                            input logic [7:0] d, input logic v, input logic [23:0] p,
                            input logic k, input logic [7:0] eb, input logic ei,
                            input string name, input int idx);
        rst_n = r; bus_addr = a; bus_we = w; tb_oe = w; tb_wd = d;
        pkt_valid = v; {pkt_st, pkt_dx, pkt_dy} = p; ack = k;
        @(posedge clk);
        #1;
        tb_oe = 1'b0; bus_we = 1'b0; pkt_valid = 1'b0; ack = 1'b0;
        #1;
        n_vec++;
        if (bus_data !== eb || irq !== ei) begin
            n_bad++;
            $display("FAIL %s[%0d]: got bus=%h irq=%b, expected bus=%h irq=%b",
                     name, idx, bus_data, irq, eb, ei);
        end
    endtask

    // Reference model: packet queue plus flags, advanced once per cycle.
    logic [23:0] mq[$];
    logic        m_ovf;
    logic        m_irq;
    int          m_cnt;

    function automatic logic [7:0] m_read(logic [2:0] off);
        int n = mq.size();
        logic [7:0] ne = (n > 0) ? 8'h01 : 8'h00;
        logic [7:0] fl = (n == Depth) ? 8'h02 : 8'h00;
        logic [7:0] ov = m_ovf ? 8'h04 : 8'h00;
        case (off)
            3'd0: return 8'((n * 16)) | ov | fl | ne;
            3'd1: return (n > 0) ? mq[0][23:16] : 8'h00;
            3'd2: return (n > 0) ? mq[0][15:8] : 8'h00;
            3'd3: return (n > 0) ? mq[0][7:0] : 8'h00;
`ifdef MOUSE_FIFO_OVF_CNT_EN
            3'd5: return 8'(m_cnt);
`endif
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] m_step(logic r, logic [7:0] a, logic w,
                                          logic [7:0] d, logic v, logic [23:0] p,
                                          logic k);
        logic       win = (a[7:3] == Base[7:3]);
        logic [7:0] eb = 8'hFF;
        logic       do_pop, do_push, do_drop, clr;
        if (!r) begin
            mq.delete(); m_ovf = 1'b0; m_irq = 1'b0; m_cnt = 0;
            return 8'hFF;
        end
        if (win && !w) eb = m_read(a[2:0]);
        do_pop  = w && win && a[2:0] == 3'd4 && mq.size() > 0;
        do_push = v && (mq.size() < Depth || do_pop);
        do_drop = v && !do_push;
        clr     = w && win && a[2:0] == 3'd0 && d[2];
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(p);
        if (clr) m_cnt = 0;
        if (do_drop && m_cnt < 255) m_cnt++;
        m_ovf = do_drop || (m_ovf && !clr);
        if (do_push) m_irq = 1'b1;
        else if (k) m_irq = 1'b0;
        return eb;
    endfunction

    initial begin
        logic [7:0] exp5;
        logic       prev_rd;

        // Directed table.
        add(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 24'h0, 1'b0, 8'hFF, 1'b0);
        add(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 24'hAABBCC, 1'b0, 8'hFF, 1'b0);
        rd(Base + 8'd0, 8'h00, 1'b0);
        rd(Base + 8'd5, 8'h00, 1'b0);
        rd(Base + 8'd6, 8'h00, 1'b0);
        rd(8'h40, 8'hFF, 1'b0);
        psh(24'h0905FB);
        rd(Base + 8'd1, 8'h09, 1'b1);
        rd(Base + 8'd2, 8'h05, 1'b1);
        rd(Base + 8'd3, 8'hFB, 1'b1);
        rd(Base + 8'd0, 8'h11, 1'b1);
        ack_row();
        wr(Base + 8'd4, 8'h00, 1'b0);
        rd(Base + 8'd0, 8'h00, 1'b0);
        for (int i = 1; i <= 5; i++)
            psh({8'(i), 8'(8'h10 + i), 8'(8'h20 + i)});
        rd(Base + 8'd0, 8'h47, 1'b1);
        rd(Base + 8'd1, 8'h01, 1'b1);
        wr(Base + 8'd4, 8'h00, 1'b1);
        rd(Base + 8'd1, 8'h02, 1'b1);
        wr(Base + 8'd4, 8'h00, 1'b1);
        rd(Base + 8'd2, 8'h13, 1'b1);
        wr(Base + 8'd4, 8'h00, 1'b1);
        rd(Base + 8'd3, 8'h24, 1'b1);
        wr(Base + 8'd4, 8'h00, 1'b1);
        rd(Base + 8'd0, 8'h04, 1'b1);
        rd(Base + 8'd1, 8'h00, 1'b1);
        wr(Base + 8'd0, 8'h04, 1'b1);
        rd(Base + 8'd0, 8'h00, 1'b1);
        ack_row();
        for (int i = 1; i <= 4; i++)
            psh({8'(8'h30 + i), 8'(8'h40 + i), 8'(8'h50 + i)});
        rd(Base + 8'd0, 8'h43, 1'b1);
        add(1'b1, Base + 8'd4, 1'b1, 8'h00, 1'b1, 24'h354555, 1'b0, 8'hFF, 1'b1);
        rd(Base + 8'd0, 8'h43, 1'b1);
        rd(Base + 8'd1, 8'h32, 1'b1);
        for (int i = 0; i < 3; i++) wr(Base + 8'd4, 8'h00, 1'b1);
        rd(Base + 8'd1, 8'h35, 1'b1);
        rd(Base + 8'd2, 8'h45, 1'b1);
        rd(Base + 8'd0, 8'h11, 1'b1);
        wr(Base + 8'd4, 8'h00, 1'b1);
        rd(Base + 8'd0, 8'h00, 1'b1);
        wr(Base + 8'd4, 8'h00, 1'b1);
        rd(Base + 8'd0, 8'h00, 1'b1);
        add(1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 24'h667686, 1'b1, 8'hFF, 1'b1);
        ack_row();
        psh(24'h677787);
        psh(24'h687888);
        add(1'b0, Base + 8'd0, 1'b0, 8'h00, 1'b0, 24'h0, 1'b0, 8'hFF, 1'b0);
        rd(Base + 8'd0, 8'h00, 1'b0);
        rd(Base + 8'd1, 8'h00, 1'b0);

        for (int i = 0; i < vecs.size(); i++)
            do_cycle(vecs[i].rst_n, vecs[i].addr, vecs[i].we, vecs[i].wd, vecs[i].v,
                     vecs[i].pkt, vecs[i].ack, vecs[i].exp_bus, vecs[i].exp_irq,
                     "vec", i);

        // Drop counter: 300 drops on a full FIFO, then clear.
`ifdef MOUSE_FIFO_OVF_CNT_EN
        exp5 = 8'hFF;
`else
        exp5 = 8'h00;
`endif
        for (int i = 0; i < 4; i++)
            do_cycle(1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 24'(i), 1'b0, 8'hFF, 1'b1, "fill", i);
        for (int i = 0; i < 300; i++)
            do_cycle(1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 24'hDEAD00, 1'b0, 8'hFF, 1'b1, "drop", i);
        do_cycle(1'b1, Base + 8'd5, 1'b0, 8'h00, 1'b0, 24'h0, 1'b0, exp5, 1'b1, "ovfcnt_sat", 0);
        do_cycle(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 24'h0, 1'b0, 8'hFF, 1'b1, "idle", 0);
        do_cycle(1'b1, Base + 8'd0, 1'b0, 8'h00, 1'b0, 24'h0, 1'b0, 8'h47, 1'b1, "stat_full", 0);
        do_cycle(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 24'h0, 1'b0, 8'hFF, 1'b1, "idle", 1);
        do_cycle(1'b1, Base + 8'd0, 1'b1, 8'h04, 1'b0, 24'h0, 1'b0, 8'hFF, 1'b1, "ovf_clr", 0);
        do_cycle(1'b1, Base + 8'd5, 1'b0, 8'h00, 1'b0, 24'h0, 1'b0, 8'h00, 1'b1, "ovfcnt_clr", 0);
        do_cycle(1'b1, Base + 8'd0, 1'b0, 8'h00, 1'b0, 24'h0, 1'b0, 8'h43, 1'b1, "stat_clr", 0);

        // Random traffic against the reference model.
        void'(m_step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 24'h0, 1'b0));
        do_cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 24'h0, 1'b0, 8'hFF, 1'b0, "rnd_rst", 0);
        prev_rd = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic        r, w, v, k;
            logic [7:0]  a, d, eb;
            logic [23:0] p;
            int          sel;
            r = ($urandom_range(0, 99) != 0);
            w = !prev_rd && ($urandom_range(0, 3) == 0);
            d = 8'($urandom);
            if (w) begin
                sel = $urandom_range(0, 4);
                a = (sel <= 2) ? Base + 8'd4 : (sel == 3) ? Base : 8'($urandom);
            end else begin
                sel = $urandom_range(0, 9);
                a = (sel < 8) ? Base + 8'(sel) : 8'($urandom);
            end
            v = ($urandom_range(0, 1) == 1);
            p = 24'($urandom);
            k = ($urandom_range(0, 7) == 0);
            eb = m_step(r, a, w, d, v, p, k);
            do_cycle(r, a, w, d, v, p, k, eb, m_irq, "rnd", i);
            prev_rd = r && !w && (a[7:3] == Base[7:3]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
